// File: rtl/mc_pkg.sv
// ============================================================================
// Module   : mc_pkg
// Brief    : State encoding, datapath mux encodings and instruction decode
//            helper shared by the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUSrcA selects
    localparam logic [1:0] c_srca_reg  = 2'b00;
    localparam logic [1:0] c_srca_pc   = 2'b01;

    // ALUSrcB selects
    localparam logic [1:0] c_srcb_reg  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_data   = 2'b01;
    localparam logic [1:0] c_res_alu    = 2'b10;

    // Instruction class codes
    localparam logic [1:0] c_op_dp  = 2'b00;
    localparam logic [1:0] c_op_mem = 2'b01;
    localparam logic [1:0] c_op_br  = 2'b10;

    // State entered after DECODE; S_FETCH marks an unsupported encoding.
    function automatic state_t decode_target(input logic [1:0] op,
                                             input logic [5:0] funct);
        state_t nxt;
        nxt = S_FETCH;
        case (op)
            c_op_dp:  nxt = funct[5] ? S_EXECI : S_EXECR;
            c_op_mem: nxt = S_MEMADR;
            c_op_br:  nxt = funct[5] ? S_BRANCH : S_FETCH;
            default:  nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multicycle processor main control FSM with memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    state_t w_dec_target;
    logic   w_no_wb;
    logic   w_unused;

    assign w_dec_target = decode_target(Op, Funct);
    // TST/TEQ/CMP/CMN only set flags, so they skip the writeback state.
    assign w_no_wb      = (Funct[4:3] == 2'b10);
    assign w_unused     = ^Funct[2:1];
    assign state_o      = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_dec_target;
            S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  w_next = w_no_wb ? S_FETCH : S_ALUWB;
            S_EXECI:  w_next = w_no_wb ? S_FETCH : S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = c_srca_reg;
        ALUSrcB    = c_srcb_reg;
        ResultSrc  = c_res_aluout;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Branch     = 1'b0;
        ALUOp      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = c_srca_pc;
                ALUSrcB   = c_srcb_four;
                ResultSrc = c_res_alu;
                // Held in reset the fetch must look like a wait cycle.
                IRWrite   = mem_ready & reset;
                NextPC    = mem_ready & reset;
            end
            S_DECODE: begin
                ALUSrcA    = c_srca_pc;
                ALUSrcB    = c_srcb_four;
                ResultSrc  = c_res_alu;
                illegal    = (w_dec_target == S_FETCH);
                instr_done = (w_dec_target == S_FETCH);
            end
            S_MEMADR: begin
                ALUSrcA = c_srca_reg;
                ALUSrcB = c_srcb_imm;
            end
            S_MEMRD: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = c_res_aluout;
            end
            S_MEMWB: begin
                ResultSrc  = c_res_data;
                RegW       = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemW       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA    = c_srca_reg;
                ALUSrcB    = c_srcb_reg;
                ALUOp      = 1'b1;
                instr_done = w_no_wb;
            end
            S_EXECI: begin
                ALUSrcA    = c_srca_reg;
                ALUSrcB    = c_srcb_imm;
                ALUOp      = 1'b1;
                instr_done = w_no_wb;
            end
            S_ALUWB: begin
                ResultSrc  = c_res_aluout;
                RegW       = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = c_srca_reg;
                ALUSrcB    = c_srcb_imm;
                ResultSrc  = c_res_alu;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Directed self-checking bench for the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       mem_req, IRWrite, NextPC, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic       RegW, MemW, Branch, ALUOp, instr_done, illegal;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fails  = 0;

    mc_control_fsm u_dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .RegW       (RegW),
        .MemW       (MemW),
        .Branch     (Branch),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] w_outs;
    assign w_outs = {mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                     RegW, MemW, Branch, ALUOp, instr_done, illegal};

    function automatic logic [15:0] pk(input logic mreq, input logic irw, input logic npc,
                                       input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic regw, input logic memw, input logic br,
                                       input logic aluop, input logic done, input logic ill);
        return {mreq, irw, npc, adr, a, b, res, regw, memw, br, aluop, done, ill};
    endfunction

    // Expected output vectors, hand-derived per state.
    logic [15:0] e_fetch_w, e_fetch_r, e_dec, e_dec_ill, e_execr, e_execi_cmp;
    logic [15:0] e_aluwb, e_memadr, e_memrd, e_memwb, e_memwr_w, e_memwr_r, e_branch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive mem_ready for one cycle, check state and outputs, advance to next cycle.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [15:0] ev);
        mem_ready = rdy;
        #1;
        check({tag, ".state"}, {28'd0, state_o}, {28'd0, st});
        check({tag, ".outs"},  {16'd0, w_outs},  {16'd0, ev});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_fetch_w   = pk(1,0,0,0,2'b01,2'b10,2'b10,0,0,0,0,0,0);
        e_fetch_r   = pk(1,1,1,0,2'b01,2'b10,2'b10,0,0,0,0,0,0);
        e_dec       = pk(0,0,0,0,2'b01,2'b10,2'b10,0,0,0,0,0,0);
        e_dec_ill   = pk(0,0,0,0,2'b01,2'b10,2'b10,0,0,0,0,1,1);
        e_execr     = pk(0,0,0,0,2'b00,2'b00,2'b00,0,0,0,1,0,0);
        e_execi_cmp = pk(0,0,0,0,2'b00,2'b01,2'b00,0,0,0,1,1,0);
        e_aluwb     = pk(0,0,0,0,2'b00,2'b00,2'b00,1,0,0,0,1,0);
        e_memadr    = pk(0,0,0,0,2'b00,2'b01,2'b00,0,0,0,0,0,0);
        e_memrd     = pk(1,0,0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0);
        e_memwb     = pk(0,0,0,0,2'b00,2'b00,2'b01,1,0,0,0,1,0);
        e_memwr_w   = pk(1,0,0,1,2'b00,2'b00,2'b00,0,1,0,0,0,0);
        e_memwr_r   = pk(1,0,0,1,2'b00,2'b00,2'b00,0,1,0,0,1,0);
        e_branch    = pk(0,0,0,0,2'b00,2'b01,2'b10,0,0,1,0,1,0);

        reset = 1'b0; mem_ready = 1'b1; Op = 2'b00; Funct = 6'd0;
        #12;
        // In reset with mem_ready high, fetch must not latch the IR.
        check("rst.state", {28'd0, state_o}, 32'd0);
        check("rst.outs",  {16'd0, w_outs},  {16'd0, e_fetch_w});
        mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // ADD register: FETCH (one wait), DECODE, EXECR, ALUWB
        Op = 2'b00; Funct = 6'b001000;
        cyc("add.fetch_wait", 1'b0, 4'd0, e_fetch_w);
        cyc("add.fetch",      1'b1, 4'd0, e_fetch_r);
        cyc("add.decode",     1'b1, 4'd1, e_dec);
        cyc("add.execr",      1'b1, 4'd6, e_execr);
        cyc("add.aluwb",      1'b1, 4'd8, e_aluwb);

        // LDR with two MEMRD wait cycles: seven cycles
        Op = 2'b01; Funct = 6'b011001;
        cyc("ldr.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("ldr.decode", 1'b1, 4'd1, e_dec);
        cyc("ldr.memadr", 1'b1, 4'd2, e_memadr);
        cyc("ldr.memrd0", 1'b0, 4'd3, e_memrd);
        cyc("ldr.memrd1", 1'b0, 4'd3, e_memrd);
        cyc("ldr.memrd2", 1'b1, 4'd3, e_memrd);
        cyc("ldr.memwb",  1'b1, 4'd4, e_memwb);

        // STR with three MEMWR wait cycles: MemW held four cycles
        Op = 2'b01; Funct = 6'b011000;
        cyc("str.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("str.decode", 1'b1, 4'd1, e_dec);
        cyc("str.memadr", 1'b1, 4'd2, e_memadr);
        cyc("str.memwr0", 1'b0, 4'd5, e_memwr_w);
        cyc("str.memwr1", 1'b0, 4'd5, e_memwr_w);
        cyc("str.memwr2", 1'b0, 4'd5, e_memwr_w);
        cyc("str.memwr3", 1'b1, 4'd5, e_memwr_r);

        // CMP immediate: EXECI finishes, no writeback
        Op = 2'b00; Funct = 6'b110101;
        cyc("cmp.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("cmp.decode", 1'b1, 4'd1, e_dec);
        cyc("cmp.execi",  1'b1, 4'd7, e_execi_cmp);

        // Op=11 is illegal
        Op = 2'b11; Funct = 6'b000000;
        cyc("ill.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("ill.decode", 1'b1, 4'd1, e_dec_ill);

        // Branch without Funct[5] is also unsupported
        Op = 2'b10; Funct = 6'b000000;
        cyc("brx.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("brx.decode", 1'b1, 4'd1, e_dec_ill);

        // B
        Op = 2'b10; Funct = 6'b100000;
        cyc("b.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("b.decode", 1'b1, 4'd1, e_dec);
        cyc("b.branch", 1'b1, 4'd9, e_branch);

        // Reset asserted mid-MEMWR abandons the store
        Op = 2'b01; Funct = 6'b011000;
        cyc("rstw.fetch",  1'b1, 4'd0, e_fetch_r);
        cyc("rstw.decode", 1'b1, 4'd1, e_dec);
        cyc("rstw.memadr", 1'b1, 4'd2, e_memadr);
        mem_ready = 1'b0;
        #1;
        check("rstw.memwr.state", {28'd0, state_o}, 32'd5);
        check("rstw.memwr.memw",  {31'd0, MemW}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rstw.async.state", {28'd0, state_o}, 32'd0);
        check("rstw.async.outs",  {16'd0, w_outs},  {16'd0, e_fetch_w});
        @(posedge clk); #1;
        check("rstw.held.state", {28'd0, state_o}, 32'd0);
        reset = 1'b1;
        #1;
        // First edge after release evaluates FETCH normally
        cyc("rstw.fetch2",  1'b1, 4'd0, e_fetch_r);
        cyc("rstw.decode2", 1'b1, 4'd1, e_dec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
